// File: rtl/secded_pkg.sv
`default_nettype none
// ============================================================================
// Module   : secded_pkg
// Purpose  : Shared helpers and types for the extended-Hamming SEC-DED blocks.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package secded_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        CORR  = 2'd1,
        FATAL = 2'd2
    } dec_res_e;

    // Number of Hamming check bits needed to cover data_w data bits.
    function automatic int calc_p(input int data_w);
        int p = 1;
        while ((1 << p) < (data_w + p + 1)) p++;
        return p;
    endfunction

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Hamming position of data bit idx: the idx-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int pos = 1;
        int cnt = -1;
        while (cnt < idx) begin
            pos++;
            if (!is_pow2(pos)) cnt++;
        end
        return pos;
    endfunction

endpackage
`default_nettype wire

// File: rtl/secded_syndrome.sv
`default_nettype none
// ============================================================================
// Module   : secded_syndrome
// Purpose  : Combinational syndrome (S) and overall parity (G) of a codeword.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module secded_syndrome #(
    parameter int CODE_W = 137,
    parameter int P      = 8
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [P-1:0]      syn_o,
    output logic              par_o
);

    always_comb begin
        syn_o = '0;
        for (int k = 0; k < CODE_W - 1; k++) begin
            if (code_i[k]) syn_o = syn_o ^ P'(k + 1);
        end
        par_o = ^code_i;
    end

endmodule
`default_nettype wire

// File: rtl/secded_dec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : secded_dec_pipe
// Purpose  : 2-stage valid/ready SEC-DED decoder with saturating event counters.
//            Define SECDED_ERR_LOG_EN to add the sticky first-error log.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module secded_dec_pipe
    import secded_pkg::*;
#(
    parameter  int DATA_W = 128,
    parameter  int CNT_W  = 16,
    localparam int P      = calc_p(DATA_W),
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CODE_W-1:0] i_code,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [P-1:0]      o_syndrome,
    output logic              o_err_corr,
    output logic              o_err_detec,
    output logic              o_err_fatal,
    input  logic              i_cnt_clr,
`ifdef SECDED_ERR_LOG_EN
    output logic              o_log_valid,
    output logic [P-1:0]      o_log_syndrome,
    output logic              o_log_fatal,
    input  logic              i_log_clr,
`endif
    output logic [CNT_W-1:0]  o_corr_cnt,
    output logic [CNT_W-1:0]  o_fatal_cnt
);

    logic [P-1:0]      syn_in;
    logic              par_in;
    logic [DATA_W-1:0] raw_data;
    logic [DATA_W-1:0] fix_data;
    dec_res_e          dec_res;

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [P-1:0]      s1_syn_q;
    logic              s1_par_q;

    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q;
    logic [P-1:0]      s2_syn_q;
    logic              s2_corr_q;
    logic              s2_fatal_q;

    logic [CNT_W-1:0]  corr_cnt_q,  corr_cnt_d;
    logic [CNT_W-1:0]  fatal_cnt_q, fatal_cnt_d;

    logic s2_free, in_xfer, out_xfer;

    assign s2_free  = !s2_valid_q || i_ready;
    assign o_ready  = !s1_valid_q || s2_free;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = s2_valid_q && i_ready;

    secded_syndrome #(
        .CODE_W (CODE_W),
        .P      (P)
    ) u_syndrome (
        .code_i (i_code),
        .syn_o  (syn_in),
        .par_o  (par_in)
    );

    // Only data bits are carried forward; check bits matter solely through S.
    for (genvar i = 0; i < DATA_W; i++) begin : g_data
        localparam int POS = data_pos(i);
        assign raw_data[i] = i_code[POS-1];
        assign fix_data[i] = s1_data_q[i] ^ ((dec_res == CORR) && (s1_syn_q == P'(POS)));
    end

    always_comb begin
        dec_res = CLEAN;
        if (s1_par_q) begin
            if (int'(s1_syn_q) <= CODE_W - 1) dec_res = CORR;
            else                              dec_res = FATAL;
        end else if (s1_syn_q != '0) begin
            dec_res = FATAL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else begin
            if (o_ready) s1_valid_q <= i_valid;
            if (in_xfer) begin
                s1_data_q <= raw_data;
                s1_syn_q  <= syn_in;
                s1_par_q  <= par_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_syn_q   <= '0;
            s2_corr_q  <= 1'b0;
            s2_fatal_q <= 1'b0;
        end else if (s2_free) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q  <= fix_data;
                s2_syn_q   <= s1_syn_q;
                s2_corr_q  <= (dec_res == CORR);
                s2_fatal_q <= (dec_res == FATAL);
            end
        end
    end

    // Clear takes priority, so a same-cycle event is intentionally lost.
    always_comb begin
        corr_cnt_d  = corr_cnt_q;
        fatal_cnt_d = fatal_cnt_q;
        if (i_cnt_clr) begin
            corr_cnt_d  = '0;
            fatal_cnt_d = '0;
        end else if (out_xfer) begin
            if (s2_corr_q && (corr_cnt_q != '1))   corr_cnt_d  = corr_cnt_q + CNT_W'(1);
            if (s2_fatal_q && (fatal_cnt_q != '1)) fatal_cnt_d = fatal_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            corr_cnt_q  <= '0;
            fatal_cnt_q <= '0;
        end else begin
            corr_cnt_q  <= corr_cnt_d;
            fatal_cnt_q <= fatal_cnt_d;
        end
    end

`ifdef SECDED_ERR_LOG_EN
    logic         log_valid_q;
    logic [P-1:0] log_syn_q;
    logic         log_fatal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            log_valid_q <= 1'b0;
            log_syn_q   <= '0;
            log_fatal_q <= 1'b0;
        end else if (i_log_clr) begin
            log_valid_q <= 1'b0;
            log_syn_q   <= '0;
            log_fatal_q <= 1'b0;
        end else if (!log_valid_q && out_xfer && (s2_corr_q || s2_fatal_q)) begin
            log_valid_q <= 1'b1;
            log_syn_q   <= s2_syn_q;
            log_fatal_q <= s2_fatal_q;
        end
    end

    assign o_log_valid    = log_valid_q;
    assign o_log_syndrome = log_syn_q;
    assign o_log_fatal    = log_fatal_q;
`endif

    assign o_valid     = s2_valid_q;
    assign o_data      = s2_data_q;
    assign o_syndrome  = s2_syn_q;
    assign o_err_corr  = s2_corr_q;
    assign o_err_fatal = s2_fatal_q;
    assign o_err_detec = s2_corr_q || s2_fatal_q;
    assign o_corr_cnt  = corr_cnt_q;
    assign o_fatal_cnt = fatal_cnt_q;

endmodule
`default_nettype wire

// File: doc/secded_dec_pipe.md
Name: secded_dec_pipe

Overview:
Parametrised extended-Hamming SEC-DED decoder, successor to the fixed 128-bit decoder. Accepts one codeword per cycle through a 2-stage valid/ready pipeline and returns corrected data with per-word error flags and syndrome. Keeps saturating correctable/fatal event counters for the memory-scrub controller. Sits between SRAM read ports and the consuming datapath.

Parameters:
DATA_W, 128, data bits per word (>=4).
CNT_W, 16, width of each event counter.
P (localparam), derived, smallest integer with 2^P >= DATA_W+P+1 (8 for DATA_W=128).
CODE_W (localparam), DATA_W+P+1 (137 for DATA_W=128).

Ports:
clk  input  1  clock; all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
i_valid  input  1  codeword on i_code is valid.
o_ready  output  1  decoder can accept i_code this cycle.
i_code  input  CODE_W  codeword, LSB-numbered [CODE_W-1:0].
o_valid  output  1  result outputs valid.
i_ready  input  1  downstream accepts the result.
o_data  output  DATA_W  corrected data.
o_syndrome  output  P  Hamming syndrome of the word.
o_err_corr  output  1  single error corrected (incl. overall-parity bit).
o_err_detec  output  1  any error detected.
o_err_fatal  output  1  uncorrectable error; o_data is raw extracted data.
i_cnt_clr  input  1  synchronous clear of both counters.
o_corr_cnt  output  CNT_W  saturating count of corrected words.
o_fatal_cnt  output  CNT_W  saturating count of fatal words.

Behaviour:
- Code layout: i_code[k], k=0..CODE_W-2, is Hamming position k+1; power-of-two positions are check bits; remaining positions carry data in ascending order (pos3=d0, pos5=d1, pos6=d2, pos7=d3, pos9=d4 ...). i_code[CODE_W-1] = overall even parity over all other bits.
- S = XOR of positions of all set bits in [CODE_W-2:0]; G = XOR of all CODE_W bits.
- Decode: S=0,G=0 -> clean. G=1,S=0 -> parity-bit error: corr=1. G=1, 1<=S<=CODE_W-1 -> flip position S: corr=1. G=1, S>CODE_W-1 -> fatal. G=0,S!=0 -> double error: fatal. detec = corr|fatal. Flags mutually exclusive except detec.
- Stage 1 registers code, S, G; stage 2 registers corrected data, syndrome, flags. Latency 2 cycles from accepted input to o_valid with i_ready held high; throughput 1 word/cycle.
- Handshake: transfer on valid&ready at either side. Stage n advances when its output register is empty or being consumed; o_ready = !s1_valid | s1_advance (combinational, no input dependence on i_valid). o_valid and all result outputs stable while o_valid=1 and i_ready=0. No word dropped or duplicated under any ready pattern.
- Counters increment on output transfer (o_valid&i_ready) of a corr/fatal word; saturate at 2^CNT_W-1. i_cnt_clr wins over same-cycle increment (event dropped).
- Reset (any time, incl. mid-stream): all valids 0, data/syndrome/flags 0, counters 0; in-flight words discarded. o_ready=1 one cycle after reset release.

Optional Feature:
SECDED_ERR_LOG_EN: adds outputs o_log_valid (1), o_log_syndrome (P), o_log_fatal (1), input i_log_clr. The first detected error after reset/clear is captured at output transfer and held (sticky) until i_log_clr; later errors ignored; i_log_clr wins over same-cycle capture. Without the macro these ports and registers do not exist; other behaviour identical.

Decomposition:
- secded_pkg: function calc_p(DATA_W), function is_pow2, function data_pos(idx) giving Hamming position of data bit idx, decode-result enum (CLEAN, CORR, FATAL).
- Sub-module secded_syndrome: combinational S/G generator over CODE_W, reused by future encoder checks.

Test Plan:
- DATA_W=128, i_code=0, i_valid=1, i_ready=1 -> 2 cycles later o_data=0, o_syndrome=0, all flags 0.
- i_code=137'h1000 (bit12, pos13=d8) -> o_data=0, o_syndrome=13, o_err_corr=1, o_err_detec=1, o_corr_cnt=1.
- i_code=137'h5000 (pos13, pos15) -> o_syndrome=2, o_err_fatal=1, o_err_corr=0, o_fatal_cnt=1.
- i_code bit136 set only -> o_syndrome=0, o_err_corr=1, o_data=0.
- Stream 8 distinct words with i_ready random 50% -> outputs in order, none lost, results held while stalled; assert reset_n mid-stream -> o_valid=0 immediately, counters 0.
- Counters with CNT_W=2: 5 corrected words -> o_corr_cnt saturates at 3; i_cnt_clr coincident with a corrected word -> count 0.
